// File: rtl/uart_word_receiver.sv
// -----------------------------------------------------------------------------
// uart_word_receiver
//
// Serial receive front-end for the CPU boot path. Samples the asynchronous rx
// line, deserialises 8N1 UART bytes and packs byte pairs into 16-bit program
// words, each presented with its RAM address as a one-cycle write strobe.
// Words are emitted in ascending address order until a full image of WORDS
// words has been delivered; after that, received bytes are ignored.
//
// Parameters:
//   CLKS_PER_BIT  ce-qualified clock cycles per UART bit (>= 4)
//   WORDS         number of words in one complete image
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   ce          clock enable; when low, all state, counters and outputs hold
//   rx          UART serial input, asynchronous, idle high
//   word_valid  registered strobe; word_data/word_adr valid (one ce-cycle)
//   word_data   assembled word; first received byte in [15:8]
//   word_adr    RAM address of the word, 0 .. WORDS-1
//   load_done   sticky; set together with the strobe of address WORDS-1
//   frame_err   sticky; set whenever a stop bit is sampled as 0
// -----------------------------------------------------------------------------
module uart_word_receiver #(
  parameter int CLKS_PER_BIT = 868,
  parameter int WORDS        = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        rx,
  output logic        word_valid,
  output logic [15:0] word_data,
  output logic [5:0]  word_adr,
  output logic        load_done,
  output logic        frame_err
);

  // Bit-period counter must hold CLKS_PER_BIT-1.
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;

  // Terminal counts: the start bit is sampled half a bit after the falling
  // edge is seen, every later sample one full bit after the previous one.
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [5:0]    LAST_ADR  = 6'(WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser. Both flops come out of reset at the idle level so that
  // reset release never looks like a start bit.
  // ---------------------------------------------------------------------------
  logic rx_meta;
  logic rx_sync;

  // NOTE: every clocked process uses non-blocking assignments so that all
  // flops update together from pre-edge values; blocking assignments here
  // would make rx_sync pick up rx in the same edge and remove a stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else if (ce) begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver FSM, byte-pair packing and output registers.
  // ---------------------------------------------------------------------------
  state_t          state;
  logic [CW-1:0]   cnt;        // ce-cycles elapsed in the current bit window
  logic [2:0]      bit_idx;    // data bits sampled so far in this byte
  logic [7:0]      shreg;      // LSB-first data shift register
  logic [7:0]      hi_byte;    // first byte of the word being assembled
  logic            phase;      // 0: next accepted byte is the high byte
  logic [5:0]      word_cnt;   // address of the next word to emit

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      hi_byte    <= '0;
      phase      <= 1'b0;
      word_cnt   <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
      word_adr   <= '0;
      load_done  <= 1'b0;
      frame_err  <= 1'b0;
    end else if (ce) begin
      // The strobe is cleared on the next enabled cycle only, so a ce gap
      // right after the stop sample stretches it rather than dropping it.
      word_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_sync) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= START;
          end
        end

        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            // A line that is already high again mid-start-bit was a glitch;
            // it is dropped silently.
            state <= rx_sync ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_sync, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_sync) begin
              // Returning to IDLE right at the stop sample leaves half a bit
              // of margin before a back-to-back start bit can be seen.
              state <= IDLE;
              if (!load_done) begin
                if (!phase) begin
                  hi_byte <= shreg;
                  phase   <= 1'b1;
                end else begin
                  word_data  <= {hi_byte, shreg};
                  word_adr   <= word_cnt;
                  word_valid <= 1'b1;
                  phase      <= 1'b0;
                  // The counter parks on the last address instead of
                  // wrapping; load_done blocks any further writes.
                  if (word_cnt == LAST_ADR) begin
                    load_done <= 1'b1;
                  end else begin
                    word_cnt <= word_cnt + 6'd1;
                  end
                end
              end
            end else begin
              // Framing error: drop the byte and resynchronise the pairing
              // so the next good byte starts a fresh word.
              frame_err <= 1'b1;
              phase     <= 1'b0;
              state     <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        WAIT_IDLE: begin
          // A stuck-low line (break) must not be taken as a new start bit.
          if (rx_sync) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_word_receiver
//
// Self-checking bench for uart_word_receiver with CLKS_PER_BIT = 16. Stimulus
// tasks serialise bytes onto rx (bit periods counted in ce-cycles) and feed a
// byte-level reference model that predicts each emitted word; predictions go
// into a queue that an independent monitor drains whenever the DUT strobes.
// -----------------------------------------------------------------------------
module tb_uart_word_receiver;

  localparam int N     = 16;      // ce-cycles per bit
  localparam int H     = N / 2;   // start-bit sample offset
  localparam int WORDS = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce  = 1'b1;
  logic        rx  = 1'b1;
  logic        word_valid;
  logic [15:0] word_data;
  logic [5:0]  word_adr;
  logic        load_done;
  logic        frame_err;

  typedef struct {
    logic [15:0] data;
    int          adr;
    bit          done;
    int          cyc;   // expected strobe cycle, 0 when not timed
  } exp_t;

  exp_t exp_q[$];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  int ce_mode   = 0;   // 0: always on, 1: 50% toggle, 2: random

  // Reference model state: byte pairing, next address, image complete, error.
  bit         m_phase;
  bit         m_done;
  bit         m_err;
  logic [7:0] m_hi;
  int         m_cnt;

  uart_word_receiver #(
    .CLKS_PER_BIT (N),
    .WORDS        (WORDS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .rx         (rx),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_adr   (word_adr),
    .load_done  (load_done),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Clock-enable driver, changes just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ce_mode)
        0:       ce = 1'b1;
        1:       ce = ~ce;
        default: ce = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every enabled cycle with the strobe high consumes one prediction.
  always @(negedge clk) begin
    if (!rst && word_valid && ce) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_strobe: got word 0x%04h at adr %0d, expected no strobe",
                 word_data, word_adr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("word_data", 32'(word_data), 32'(e.data));
        check("word_adr", 32'(word_adr), 32'(e.adr));
        check("load_done_at_strobe", 32'(load_done), 32'(e.done));
        if (e.cyc != 0) check("strobe_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic model_reset();
    m_phase = 1'b0;
    m_done  = 1'b0;
    m_err   = 1'b0;
    m_hi    = 8'h00;
    m_cnt   = 0;
    exp_q.delete();
  endtask

  // Predict the effect of one frame. Called right before the frame's start
  // bit is driven, so cyc is the edge after which the pin falls.
  task automatic model_byte(input logic [7:0] b, input bit good);
    exp_t e;
    if (!good) begin
      m_err   = 1'b1;
      m_phase = 1'b0;
    end else if (!m_done) begin
      if (!m_phase) begin
        m_hi    = b;
        m_phase = 1'b1;
      end else begin
        e.data = {m_hi, b};
        e.adr  = m_cnt;
        e.done = (m_cnt == WORDS - 1);
        // Pin seen by the FSM 3 edges later; stop sample after H + 9 bits.
        e.cyc  = (ce_mode == 0) ? cyc + 3 + H + 9 * N : 0;
        exp_q.push_back(e);
        m_phase = 1'b0;
        m_cnt++;
        if (m_cnt == WORDS) m_done = 1'b1;
      end
    end
  endtask

  // Drive one bit level for N enabled clock edges.
  task automatic hold_bit(input logic v);
    int n;
    n  = 0;
    rx = v;
    while (n < N) begin
      @(posedge clk);
      if (ce) n++;
    end
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit good);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(b[i]);
    hold_bit(good);
    if (!good) hold_bit(1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good);
    model_byte(b, good);
    send_frame(b, good);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx  = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic finish_test(input string name);
    repeat (3) hold_bit(1'b1);
    check({name, "_all_strobes_seen"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] rb;
    bit         rgood;

    // Reset values.
    do_reset();
    check("rst_word_valid", 32'(word_valid), 32'd0);
    check("rst_word_data", 32'(word_data), 32'h0000);
    check("rst_word_adr", 32'(word_adr), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);

    // Single word with strobe timing.
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    finish_test("single");
    check("single_word_data", 32'(word_data), 32'h1234);
    check("single_frame_err", 32'(frame_err), 32'd0);
    check("single_load_done", 32'(load_done), 32'd0);

    // Full image, back-to-back frames, then bytes after completion.
    do_reset();
    for (int i = 0; i < WORDS; i++) begin
      send_byte(8'h00, 1'b1);
      send_byte(8'(i), 1'b1);
    end
    check("image_load_done", 32'(load_done), 32'd1);
    send_byte(8'hC3, 1'b1);
    send_byte(8'h3C, 1'b1);
    finish_test("image");
    check("post_done_word_adr", 32'(word_adr), 32'd63);
    check("post_done_word_data", 32'(word_data), 32'h003F);
    check("post_done_load_done", 32'(load_done), 32'd1);

    // Start-bit glitch shorter than half a bit.
    do_reset();
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (12) hold_bit(1'b1);
    check("glitch_frame_err", 32'(frame_err), 32'd0);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    finish_test("glitch");
    check("glitch_word_data", 32'(word_data), 32'h1122);

    // Framing error discards the byte and re-pairs from the next one.
    do_reset();
    send_byte(8'h99, 1'b1);
    send_byte(8'hAB, 1'b0);
    check("ferr_set", 32'(frame_err), 32'd1);
    send_byte(8'hCD, 1'b1);
    send_byte(8'hEF, 1'b1);
    finish_test("ferr");
    check("ferr_sticky", 32'(frame_err), 32'd1);
    check("ferr_word_data", 32'(word_data), 32'hCDEF);
    check("ferr_word_adr", 32'(word_adr), 32'd0);

    // 50% clock enable.
    do_reset();
    ce_mode = 1;
    send_byte(8'h5A, 1'b1);
    send_byte(8'hA5, 1'b1);
    finish_test("ce_toggle");
    ce_mode = 0;
    check("ce_toggle_word_data", 32'(word_data), 32'h5AA5);

    // Asynchronous reset after the first byte of a word.
    repeat (2) hold_bit(1'b1);
    send_byte(8'h42, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_word_data", 32'(word_data), 32'h0000);
    check("async_rst_word_valid", 32'(word_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    send_byte(8'h77, 1'b1);
    send_byte(8'h88, 1'b1);
    finish_test("after_rst");
    check("after_rst_word_data", 32'(word_data), 32'h7788);
    check("after_rst_word_adr", 32'(word_adr), 32'd0);
    check("after_rst_flags", 32'({load_done, frame_err}), 32'd0);

    // Randomised bytes, stop-bit errors, idle gaps and clock enable.
    do_reset();
    ce_mode = 2;
    for (int i = 0; i < 40; i++) begin
      rb    = 8'($urandom);
      rgood = ($urandom_range(0, 7) != 0);
      send_byte(rb, rgood);
      repeat ($urandom_range(0, 2)) hold_bit(1'b1);
    end
    finish_test("random");
    ce_mode = 0;
    check("random_frame_err", 32'(frame_err), 32'(m_err));
    check("random_load_done", 32'(load_done), 32'(m_done));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
